// File: rtl/yolo_pkg.sv
// Shared definitions for the YOLO streaming layers: FP32 field layout and
// a constant-evaluable ceil(log2) used to size counters.
package yolo_pkg;

  localparam int FP32_WIDTH = 32;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] mant;
  } fp32_t;

  // ceil(log2(n)), returning at least 1 so that counters are never zero-width
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/layer_5_maxpool_stream_fp32_max.sv
// Combinational FP32 maximum under a sign-magnitude total order:
// positive beats negative (so -0.0 < +0.0), larger magnitude wins among
// positives, smaller magnitude wins among negatives, ties return a.
module fp32_max
  import yolo_pkg::*;
(
  input  logic [FP32_WIDTH-1:0] a,
  input  logic [FP32_WIDTH-1:0] b,
  output logic [FP32_WIDTH-1:0] y
);

  fp32_t fa;
  fp32_t fb;
  logic  b_wins;

  assign fa = a;
  assign fb = b;

  // Pick b only when it is strictly greater; equality falls through to a
  always_comb begin
    b_wins = 1'b0;
    if (fa.sign != fb.sign) begin
      b_wins = fa.sign;
    end else if (!fa.sign) begin
      b_wins = ({fb.exp, fb.mant} > {fa.exp, fa.mant});
    end else begin
      b_wins = ({fb.exp, fb.mant} < {fa.exp, fa.mant});
    end
    y = b_wins ? b : a;
  end

endmodule

// File: rtl/layer_5_maxpool_stream.sv
// Streaming 2x2 / stride-2 FP32 max-pool over a raster-order feature map.
// Even rows fold horizontal pairs into a half-width line buffer; odd rows
// fold their pair with the buffered value and emit one pooled pixel.
module layer_5_maxpool_stream
  import yolo_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int IMG_SIZE   = 104
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  valid_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic                  frame_done
);

  localparam int CW = clog2(IMG_SIZE);
  localparam int LW = (CW > 1) ? CW - 1 : 1;
  localparam logic [CW-1:0] LAST = CW'(IMG_SIZE - 1);

  logic [CW-1:0]         col;
  logic [CW-1:0]         row;
  logic [DATA_WIDTH-1:0] hold;
  logic [DATA_WIDTH-1:0] lbuf [IMG_SIZE/2];
  logic [LW-1:0]         lidx;
  logic [DATA_WIDTH-1:0] pair_max;
  logic [DATA_WIDTH-1:0] win_max;

  assign lidx = LW'(col >> 1);

  // Horizontal pair: left pixel (held) against the current right pixel
  fp32_max u_max_pair (
    .a (hold),
    .b (data_in),
    .y (pair_max)
  );

  // Vertical fold: current-row pair against the pair buffered from the row above
  fp32_max u_max_col (
    .a (pair_max),
    .b (lbuf[lidx]),
    .y (win_max)
  );

  // Line buffer holds even-row pair maxima; no reset, always written before read
  always_ff @(posedge Clk) begin
    if (valid_in && col[0] && !row[0]) begin
      lbuf[lidx] <= pair_max;
    end
  end

  // Raster counters, left-pixel hold register and registered pooled output
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      col        <= '0;
      row        <= '0;
      hold       <= '0;
      data_out   <= '0;
      valid_out  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      valid_out  <= 1'b0;
      frame_done <= 1'b0;
      if (valid_in) begin
        if (col == LAST) begin
          col <= '0;
          row <= (row == LAST) ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
        if (!col[0]) begin
          hold <= data_in;
        end else if (row[0]) begin
          data_out   <= win_max;
          valid_out  <= 1'b1;
          frame_done <= (row == LAST) && (col == LAST);
        end
      end
    end
  end

endmodule
